// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, default address map and lane helpers for the data-memory bridge
package dmem_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] DEF_IO_ADDR = 32'h1001_FFFC;
  function automatic logic [3:0] lane_wmask(input logic [1:0] size, input logic [1:0] a);
    return size == BYTE ? 4'b0001 << a :
           size == HALF ? (a[1] ? 4'b1100 : 4'b0011) :
           size == WORD ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] a, input logic u);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    return size == BYTE ? {{24{b[7] & ~u}}, b} :
           size == HALF ? {{16{h[15] & ~u}}, h} : w;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM with byte write enables and registered read
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: handshaked byte/half/word data-memory controller with one memory-mapped display register
module dmem_mmio_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [31:0] IO_ADDR = DEF_IO_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] disp_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e state, state_n;
  logic cap_we, cap_uns, accept, ram_hit, io_hit, err;
  logic [1:0] cap_size;
  logic [31:0] cap_addr, cap_wdata, off, wdata_rep, ram_rdata, load_word;
  logic [3:0] ram_we;
  logic [AW-1:0] ram_addr;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  assign off = cap_addr - DATA_BASE;
  assign ram_hit = cap_addr >= DATA_BASE && off < 32'(4 * DEPTH_WORDS);
  assign io_hit = cap_addr == IO_ADDR && cap_size == WORD;
  assign err = cap_size == 2'd3 || (cap_size == HALF && cap_addr[0]) ||
               (cap_size == WORD && |cap_addr[1:0]) || !(ram_hit || io_hit);
  assign wdata_rep = cap_size == BYTE ? {4{cap_wdata[7:0]}} :
                     cap_size == HALF ? {2{cap_wdata[15:0]}} : cap_wdata;
  assign ram_we = (state == ACCESS && cap_we && ram_hit && !err) ? lane_wmask(cap_size, cap_addr[1:0]) : 4'b0000;
  // Read uses the live address at accept; the write in ACCESS uses the captured one.
  assign ram_addr = state == ACCESS ? off[AW+1:2] : AW'((req_addr - DATA_BASE) >> 2);
  assign load_word = io_hit ? disp_data : load_extend(ram_rdata, cap_size, cap_addr[1:0], cap_uns);
  always_comb begin
    state_n = state == IDLE ? (req_valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end
  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk(clk), .en(accept || state == ACCESS), .we(ram_we),
    .addr(ram_addr), .wdata(wdata_rep), .rdata(ram_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cap_we <= 1'b0;
      cap_uns <= 1'b0;
      cap_size <= 2'd0;
      cap_addr <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      disp_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cap_we <= req_we;
        cap_uns <= req_unsigned;
        cap_size <= req_size;
        cap_addr <= req_addr;
        cap_wdata <= req_wdata;
      end
      if (state == ACCESS) begin
        rsp_err <= err;
        rsp_rdata <= (err || cap_we) ? 32'h0 : load_word;
        if (io_hit && cap_we) disp_data <= cap_wdata;
      end
    end
endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb_dmem_mmio_bridge: directed table-driven bench for dmem_mmio_bridge
module tb_dmem_mmio_bridge;
  localparam logic [31:0] IO = 32'h1001_FFFC;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, disp_data;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic we;
    logic [1:0] size;
    logic uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  vec_t tbl[$];

  dmem_mmio_bridge dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic e);
    vec_t v;
    v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s ready_timeout: got 0 expected 1", nm);
    end
  endtask

  task automatic xact(input string nm, input vec_t v);
    wait_ready(nm);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " access_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, " access_ready"}, {31'b0, req_ready}, 32'd0);
    req_we = ~v.we; req_size = 2'd2; req_addr = 32'h1001_0000; req_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({nm, " rdata"}, rsp_rdata, v.rdata);
    chk({nm, " err"}, {31'b0, rsp_err}, {31'b0, v.err});
    @(posedge clk);
    @(negedge clk);
    chk({nm, " idle_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, " idle_ready"}, {31'b0, req_ready}, 32'd1);
    chk({nm, " rdata_hold"}, rsp_rdata, v.rdata);
    req_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    add(1, 2, 0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 0);
    add(0, 2, 0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 0);
    add(1, 0, 0, 32'h1001_0005, 32'h0000_0080, 32'h0, 0);
    add(0, 0, 0, 32'h1001_0005, 32'h0, 32'hFFFF_FF80, 0);
    add(0, 0, 1, 32'h1001_0005, 32'h0, 32'h0000_0080, 0);
    add(0, 2, 0, 32'h1001_0004, 32'h0, 32'hDEAD_80EF, 0);
    add(0, 1, 0, 32'h1001_0006, 32'h0, 32'hFFFF_DEAD, 0);
    add(0, 1, 1, 32'h1001_0006, 32'h0, 32'h0000_DEAD, 0);
    add(1, 2, 0, 32'h1001_0000, 32'h1122_3344, 32'h0, 0);
    add(1, 1, 0, 32'h1001_0001, 32'h0000_5555, 32'h0, 1);
    add(0, 2, 0, 32'h1001_0000, 32'h0, 32'h1122_3344, 0);
    add(1, 2, 0, 32'h1001_1000, 32'h6666_6666, 32'h0, 1);
    add(0, 2, 0, 32'h1001_0000, 32'h0, 32'h1122_3344, 0);
    add(1, 3, 0, 32'h1001_0000, 32'h7777_7777, 32'h0, 1);
    add(0, 2, 0, 32'h1001_0000, 32'h0, 32'h1122_3344, 0);
    add(1, 1, 0, 32'h1001_0002, 32'h0000_BEEF, 32'h0, 0);
    add(0, 2, 0, 32'h1001_0000, 32'h0, 32'hBEEF_3344, 0);
    add(0, 0, 0, 32'h1001_0003, 32'h0, 32'hFFFF_FFBE, 0);
    add(0, 0, 1, 32'h1001_0000, 32'h0, 32'h0000_0044, 0);
    add(0, 2, 0, 32'h1001_0002, 32'h0, 32'h0, 1);
    add(1, 2, 0, 32'h1001_0FFC, 32'hCAFE_F00D, 32'h0, 0);
    add(0, 2, 0, 32'h1001_0FFC, 32'h0, 32'hCAFE_F00D, 0);
    add(0, 2, 0, 32'h1000_FFFC, 32'h0, 32'h0, 1);
    add(1, 2, 0, 32'h1001_0008, 32'h5566_7788, 32'h0, 0);

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_disp", disp_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) xact($sformatf("v%0d", i), tbl[i]);

    // Display register store: value must appear at T1, not before.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = IO; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("io_disp_before_t1", disp_data, 32'h0);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("io_disp_at_t1", disp_data, 32'h1234_5678);
    chk("io_sw_err", {31'b0, rsp_err}, 32'd0);
    chk("io_sw_valid", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v = '{we: 0, size: 2, uns: 0, addr: IO, wdata: 0, rdata: 32'h1234_5678, err: 0};
    xact("io_lw", v);
    v = '{we: 1, size: 0, uns: 0, addr: IO, wdata: 32'h0000_00AB, rdata: 0, err: 1};
    xact("io_sb", v);
    chk("io_sb_disp", disp_data, 32'h1234_5678);
    v = '{we: 0, size: 1, uns: 0, addr: IO, wdata: 0, rdata: 0, err: 1};
    xact("io_lh", v);

    // Reset during ACCESS aborts the store and suppresses the response.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h1001_0008; req_wdata = 32'hAAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_disp", disp_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_valid2", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid3", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rdata", rsp_rdata, 32'h0);
    v = '{we: 0, size: 2, uns: 0, addr: 32'h1001_0008, wdata: 0, rdata: 32'h5566_7788, err: 0};
    xact("abort_lw", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_mmio_bridge.md
# dmem_mmio_bridge

Parametrised data-memory controller that replaces the fixed 128-word DMEM and the external address arithmetic in the single-cycle SoC top. It accepts one load/store request at a time over a valid/ready handshake and translates the CPU byte address against a configurable base. It performs byte/halfword/word accesses with byte-lane writes and sign/zero-extended loads, and flags misaligned or out-of-range accesses. It also decodes one memory-mapped display register that feeds the seven-segment driver.

## Interface
Parameters:
- `DATA_BASE`, 32'h1001_0000: byte address of word 0 of the RAM.
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, 16..65536.
- `IO_ADDR`, 32'h1001_FFFC: word address of the display register; must lie outside the RAM window.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: CPU byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: access rejected, valid with `rsp_valid`.
- `disp_data` out 32: display register contents.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE→ACCESS on `req_valid && req_ready`; request fields are captured into internal registers.
  - ACCESS→RESP unconditionally.
  - RESP→IDLE unconditionally.
- Decode, from captured fields:
  - RAM hit when `DATA_BASE <= addr < DATA_BASE + 4*DEPTH_WORDS`; word index = (addr − DATA_BASE) >> 2, using log2(DEPTH_WORDS) bits.
  - IO hit when `addr == IO_ADDR` and size = word.
- Error conditions, any of:
  - size = 3;
  - half with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - no RAM hit and no IO hit, including a non-word access to IO_ADDR.
  On error nothing is written, `rsp_rdata` = 0, `rsp_err` = 1.
- Lanes are little-endian: byte k occupies bits [8k+7:8k], k = addr[1:0]. A half at addr[1] = h occupies [16h+15:16h].
- Store: only the addressed lanes are written, using replicated `req_wdata`; other bytes are unchanged. An IO store writes all 32 bits of `disp_data`.
- Load: the addressed lane is extracted, shifted to bit 0, then sign- or zero-extended per `req_unsigned`. An IO load returns `disp_data`. `req_unsigned` is ignored for word loads.
- RAM contents are not reset and have undefined initial contents.

## Timing
- Reset values: state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `disp_data` 0.
- Accept edge T0 (IDLE→ACCESS). The RAM is read synchronously at T0 using the live `req_addr` word index.
- Edge T1 (ACCESS→RESP):
  - store bytes, or `disp_data`, are committed;
  - `rsp_rdata` and `rsp_err` are registered;
  - `rsp_valid` rises.
- Edge T2 (RESP→IDLE): `rsp_valid` falls and `req_ready` rises.
- Latency: response visible 1 cycle after the accept cycle. Throughput: 1 request per 3 cycles. There is no response back-pressure.
- `rsp_rdata` and `rsp_err` hold their values until the next T1.
- Reset asserted in ACCESS aborts the transaction: no write, no response. Reset in RESP drops `rsp_valid` immediately; a write already committed at T1 stays.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Package `dmem_pkg` contains:
  - `size_e` (BYTE, HALF, WORD);
  - `state_e` (IDLE, ACCESS, RESP);
  - default `DATA_BASE` and `IO_ADDR` constants;
  - pure functions `lane_wmask(size, addr[1:0])` and `load_extend(word, size, addr[1:0], unsigned)`.
- Sub-module `dmem_ram`: single-port synchronous RAM, `DEPTH_WORDS`×32, 4 byte-write-enables, registered read.

## Test plan
- Reset: hold `rst_n` = 0 → all outputs at reset values and `req_ready` = 1.
- SW 0xDEADBEEF @0x1001_0004, then LW @0x1001_0004 → `rsp_rdata` 0xDEADBEEF, `rsp_err` 0, response exactly 1 cycle after each accept.
- After the previous step, SB 0x80 @0x1001_0005:
  - LB → 0xFFFF_FF80;
  - LBU → 0x0000_0080;
  - LW → 0xDEAD_80EF.
- Error cases, each → `rsp_err` 1 and `rsp_rdata` 0, with a following LW @0x1001_0000 showing the word unchanged:
  - SH @0x1001_0001;
  - SW @`DATA_BASE`+4·`DEPTH_WORDS`;
  - size 3 @0x1001_0000.
- SW 0x1234_5678 @`IO_ADDR` → `disp_data` changes at T1 → LW returns 0x1234_5678. SB @`IO_ADDR` → `rsp_err` 1 and `disp_data` unchanged.
- SW 0xAAAA_AAAA @0x1001_0008 with `rst_n` pulsed low during ACCESS → no `rsp_valid`, FSM in IDLE, and a subsequent LW @0x1001_0008 does not return 0xAAAA_AAAA; its prior content (preloaded) is preserved.
